// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-side arbiter that shares one FIFO write
// port among NUM_REQ valid/ready producers. A grant lasts at most MAX_BURST
// beats and never issues a write while the FIFO reports full.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [DATA_W-1:0]          fifo_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_owner;
    logic [ID_W-1:0]   w_owner_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   w_rr_ptr_nxt;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [CNT_W-1:0]  w_beat_cnt_nxt;
    logic [DATA_W-1:0] w_data_arr [NUM_REQ];

    // Increment an index modulo NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
        if (x == ID_W'(NUM_REQ - 1))
            wrap_inc = '0;
        else
            wrap_inc = x + 1'b1;
    endfunction

    // First requesting index at or above ptr, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] cand;
        logic            found;
        rr_pick = ptr;
        cand    = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
            cand = wrap_inc(cand);
        end
    endfunction

    // Unpack the flat producer data bus into one word per producer.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Next-state, arbitration and FIFO-side outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        req_ready      = '0;
        fifo_wr_en     = 1'b0;
        fifo_data      = '0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_owner_nxt    = rr_pick(req_valid, r_rr_ptr);
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                req_ready[r_owner] = ~fifo_full;
                fifo_wr_en         = req_valid[r_owner] & ~fifo_full;
                fifo_data          = w_data_arr[r_owner];
                if (fifo_wr_en) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    if (r_beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                        w_rr_ptr_nxt = wrap_inc(r_owner);
                        w_state_nxt  = ST_IDLE;
                    end
                end else if (!req_valid[r_owner]) begin
                    // Owner dropped valid: grant is forfeited, no write this cycle.
                    w_rr_ptr_nxt = wrap_inc(r_owner);
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State registers; asynchronous reset abandons any burst immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    assign grant_id = r_owner;
    assign busy     = (r_state == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic checked against a cycle-level model of the arbiter rules.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_data;
    logic [1:0]        grant_id;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] d;
        logic        f;
        logic [3:0]  er;
        logic        ew;
        logic [7:0]  efd;
        logic [1:0]  eg;
        logic        eb;
    } vec_t;

    vec_t tbl[$];

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d, input logic f,
                       input logic [3:0] er, input logic ew, input logic [7:0] efd,
                       input logic [1:0] eg, input logic eb);
        vec_t e;
        e = '{r, v, d, f, er, ew, efd, eg, eb};
        tbl.push_back(e);
    endtask

    // One cycle: drive inputs just after the rising edge, check at the falling edge.
    task automatic cyc(input string nm, input logic r, input logic [3:0] v, input logic [31:0] d,
                       input logic f, input logic [3:0] er, input logic ew, input logic [7:0] efd,
                       input logic [1:0] eg, input logic eb);
        rst_n     = ~r;
        req_valid = v;
        req_data  = d;
        fifo_full = f;
        @(negedge clk);
        chk({nm, ".ready"}, 32'(req_ready), 32'(er));
        chk({nm, ".wr_en"}, 32'(fifo_wr_en), 32'(ew));
        chk({nm, ".data"}, 32'(fifo_data), 32'(efd));
        chk({nm, ".grant_id"}, 32'(grant_id), 32'(eg));
        chk({nm, ".busy"}, 32'(busy), 32'(eb));
        @(posedge clk);
        #1;
    endtask

    // Random-phase producer state and reference model.
    logic [3:0]  pv;
    logic [5:0]  seq  [NR];
    logic [5:0]  wseq [NR];
    logic        m_busy;
    int          m_owner, m_next, m_beats;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
        @(posedge clk);
        #1;

        // Burst split: six beats from producer 0, MAX_BURST 4.
        add(1, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        add(0, 4'h1, 32'h000000A0, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        add(0, 4'h1, 32'h000000A0, 0, 4'h1, 1, 8'hA0, 2'd0, 1);
        add(0, 4'h1, 32'h000000A1, 0, 4'h1, 1, 8'hA1, 2'd0, 1);
        add(0, 4'h1, 32'h000000A2, 0, 4'h1, 1, 8'hA2, 2'd0, 1);
        add(0, 4'h1, 32'h000000A3, 0, 4'h1, 1, 8'hA3, 2'd0, 1);
        add(0, 4'h1, 32'h000000A4, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        add(0, 4'h1, 32'h000000A4, 0, 4'h1, 1, 8'hA4, 2'd0, 1);
        add(0, 4'h1, 32'h000000A5, 0, 4'h1, 1, 8'hA5, 2'd0, 1);
        add(0, 4'h0, 32'h00000000, 0, 4'h1, 0, 8'h00, 2'd0, 1);
        add(0, 4'h0, 32'h00000000, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        // Round-robin fairness with wrap back to producer 0.
        add(1, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        add(0, 4'hF, 32'h40302010, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        add(0, 4'hF, 32'h40302010, 0, 4'h1, 1, 8'h10, 2'd0, 1);
        add(0, 4'hE, 32'h40302000, 0, 4'h1, 0, 8'h00, 2'd0, 1);
        add(0, 4'hE, 32'h40302000, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        add(0, 4'hE, 32'h40302000, 0, 4'h2, 1, 8'h20, 2'd1, 1);
        add(0, 4'hC, 32'h40300000, 0, 4'h2, 0, 8'h00, 2'd1, 1);
        add(0, 4'hC, 32'h40300000, 0, 4'h0, 0, 8'h00, 2'd1, 0);
        add(0, 4'hC, 32'h40300000, 0, 4'h4, 1, 8'h30, 2'd2, 1);
        add(0, 4'h8, 32'h40000000, 0, 4'h4, 0, 8'h00, 2'd2, 1);
        add(0, 4'h8, 32'h40000000, 0, 4'h0, 0, 8'h00, 2'd2, 0);
        add(0, 4'h8, 32'h40000000, 0, 4'h8, 1, 8'h40, 2'd3, 1);
        add(0, 4'h3, 32'h00006050, 0, 4'h8, 0, 8'h00, 2'd3, 1);
        add(0, 4'h3, 32'h00006050, 0, 4'h0, 0, 8'h00, 2'd3, 0);
        add(0, 4'h3, 32'h00006050, 0, 4'h1, 1, 8'h50, 2'd0, 1);
        add(0, 4'h2, 32'h00006000, 0, 4'h1, 0, 8'h00, 2'd0, 1);
        add(0, 4'h2, 32'h00006000, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        add(0, 4'h2, 32'h00006000, 0, 4'h2, 1, 8'h60, 2'd1, 1);
        add(0, 4'h0, 32'h00000000, 0, 4'h2, 0, 8'h00, 2'd1, 1);
        add(0, 4'h0, 32'h00000000, 0, 4'h0, 0, 8'h00, 2'd1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc($sformatf("tbl%0d", i), tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].f,
                tbl[i].er, tbl[i].ew, tbl[i].efd, tbl[i].eg, tbl[i].eb);
        end

        // Full stall: owner 2, full high for 5 cycles after the first beat.
        cyc("stl", 1, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        cyc("stl", 0, 4'h4, 32'h00C00000, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        cyc("stl", 0, 4'h4, 32'h00C00000, 0, 4'h4, 1, 8'hC0, 2'd2, 1);
        repeat (5) cyc("stl.full", 0, 4'h4, 32'h00C10000, 1, 4'h0, 0, 8'hC1, 2'd2, 1);
        cyc("stl", 0, 4'h4, 32'h00C10000, 0, 4'h4, 1, 8'hC1, 2'd2, 1);
        cyc("stl", 0, 4'h4, 32'h00C20000, 0, 4'h4, 1, 8'hC2, 2'd2, 1);
        cyc("stl", 0, 4'h0, 32'h00000000, 0, 4'h4, 0, 8'h00, 2'd2, 1);
        cyc("stl", 0, 4'h0, 32'h00000000, 0, 4'h0, 0, 8'h00, 2'd2, 0);

        // Early valid drop: owner 1 forfeits, pending producer 3 goes first.
        cyc("drp", 1, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        cyc("drp", 0, 4'h2, 32'h0000B000, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        cyc("drp", 0, 4'hA, 32'hD000B000, 0, 4'h2, 1, 8'hB0, 2'd1, 1);
        cyc("drp", 0, 4'hA, 32'hD000B100, 0, 4'h2, 1, 8'hB1, 2'd1, 1);
        cyc("drp", 0, 4'h8, 32'hD0000000, 0, 4'h2, 0, 8'h00, 2'd1, 1);
        cyc("drp", 0, 4'hA, 32'hD000B200, 0, 4'h0, 0, 8'h00, 2'd1, 0);
        cyc("drp", 0, 4'hA, 32'hD000B200, 0, 4'h8, 1, 8'hD0, 2'd3, 1);
        cyc("drp", 0, 4'h2, 32'h0000B200, 0, 4'h8, 0, 8'h00, 2'd3, 1);
        cyc("drp", 0, 4'h2, 32'h0000B200, 0, 4'h0, 0, 8'h00, 2'd3, 0);
        cyc("drp", 0, 4'h2, 32'h0000B200, 0, 4'h2, 1, 8'hB2, 2'd1, 1);
        cyc("drp", 0, 4'h0, 32'h00000000, 0, 4'h2, 0, 8'h00, 2'd1, 1);
        cyc("drp", 0, 4'h0, 32'h00000000, 0, 4'h0, 0, 8'h00, 2'd1, 0);

        // Reset mid-burst (rr_ptr is 2 beforehand; restart must be from 0).
        cyc("rst", 0, 4'h4, 32'h00E00000, 0, 4'h0, 0, 8'h00, 2'd1, 0);
        cyc("rst", 0, 4'h4, 32'h00E00000, 0, 4'h4, 1, 8'hE0, 2'd2, 1);
        req_valid = 4'h4;
        req_data  = 32'h00E10000;
        #2;
        chk("rst.pre.wr_en", 32'(fifo_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst.async.wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst.async.ready", 32'(req_ready), 32'd0);
        chk("rst.async.busy", 32'(busy), 32'd0);
        chk("rst.async.grant_id", 32'(grant_id), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst.held.wr_en", 32'(fifo_wr_en), 32'd0);
            chk("rst.held.busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        cyc("rst", 0, 4'h5, 32'h00E100F0, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        cyc("rst", 0, 4'h5, 32'h00E100F0, 0, 4'h1, 1, 8'hF0, 2'd0, 1);
        cyc("rst", 0, 4'h4, 32'h00E10000, 0, 4'h1, 0, 8'h00, 2'd0, 1);
        cyc("rst", 0, 4'h4, 32'h00E10000, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        cyc("rst", 0, 4'h4, 32'h00E10000, 0, 4'h4, 1, 8'hE1, 2'd2, 1);
        cyc("rst", 0, 4'h0, 32'h00000000, 0, 4'h4, 0, 8'h00, 2'd2, 1);

        // Randomized traffic against the reference model.
        cyc("rnd.reset", 1, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        rst_n = 1'b1;
        pv = '0;
        for (int i = 0; i < NR; i++) begin
            seq[i]  = '0;
            wseq[i] = '0;
        end
        m_busy = 1'b0; m_owner = 0; m_next = 0; m_beats = 0;
        for (int c = 0; c < 2000; c++) begin
            logic [3:0]  er;
            logic        ew;
            logic [7:0]  efd;
            logic        found;
            for (int i = 0; i < NR; i++) begin
                if (!pv[i])
                    pv[i] = ($urandom_range(0, 2) == 0);
                else if ($urandom_range(0, 19) == 0)
                    pv[i] = 1'b0;
                req_data[i*DW +: DW] = {2'(i), seq[i]};
            end
            req_valid = pv;
            fifo_full = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            er  = (m_busy && !fifo_full) ? 4'(1 << m_owner) : 4'h0;
            ew  = m_busy && req_valid[m_owner] && !fifo_full;
            efd = m_busy ? req_data[m_owner*DW +: DW] : 8'h00;
            chk("rnd.ready", 32'(req_ready), 32'(er));
            chk("rnd.wr_en", 32'(fifo_wr_en), 32'(ew));
            chk("rnd.data", 32'(fifo_data), 32'(efd));
            chk("rnd.grant_id", 32'(grant_id), 32'(m_owner));
            chk("rnd.busy", 32'(busy), 32'(m_busy));
            chk("rnd.wr_while_full", 32'(fifo_wr_en & fifo_full), 32'd0);
            chk("rnd.ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (fifo_wr_en) begin
                chk("rnd.order", 32'(fifo_data[5:0]), 32'(wseq[fifo_data[7:6]]));
                wseq[fifo_data[7:6]] = fifo_data[5:0] + 6'd1;
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    seq[i] = seq[i] + 6'd1;
                    if ($urandom_range(0, 2) == 0) pv[i] = 1'b0;
                end
            end
            if (!m_busy) begin
                if (req_valid != 4'h0) begin
                    found = 1'b0;
                    for (int k = 0; k < NR; k++) begin
                        if (!found && req_valid[(m_next + k) % NR]) begin
                            m_owner = (m_next + k) % NR;
                            found   = 1'b1;
                        end
                    end
                    m_busy  = 1'b1;
                    m_beats = 0;
                end
            end else if (ew) begin
                m_beats++;
                if (m_beats == MB) begin
                    m_busy = 1'b0;
                    m_next = (m_owner + 1) % NR;
                end
            end else if (!req_valid[m_owner]) begin
                m_busy = 1'b0;
                m_next = (m_owner + 1) % NR;
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
